// File: rtl/mdiv_pkg.sv
// Shared types, constants and special-case helper for the RISC-V divide controller.
// Width is fixed at MDIV_XLEN; the controller's XLEN must match it.
package mdiv_pkg;

    localparam int MDIV_XLEN = 32;

    localparam logic [MDIV_XLEN-1:0] MDIV_ALL_ONES = {MDIV_XLEN{1'b1}};
    localparam logic [MDIV_XLEN-1:0] MDIV_INT_MIN  = {1'b1, {(MDIV_XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        MDIV_IDLE,
        MDIV_BUSY,
        MDIV_DONE,
        MDIV_DRAIN
    } mdiv_state_t;

    typedef struct packed {
        logic                 is_special;
        logic [MDIV_XLEN-1:0] result;
    } mdiv_special_t;

    // RISC-V defines divide-by-zero and INT_MIN / -1 without trapping.
    function automatic mdiv_special_t mdiv_special_result(
        input logic                 unsign,
        input logic                 rem,
        input logic [MDIV_XLEN-1:0] dividend,
        input logic [MDIV_XLEN-1:0] divisor
    );
        mdiv_special_t res;
        res = '0;
        if (divisor == '0) begin
            res.is_special = 1'b1;
            res.result     = rem ? dividend : MDIV_ALL_ONES;
        end else if (!unsign && dividend == MDIV_INT_MIN && divisor == MDIV_ALL_ONES) begin
            res.is_special = 1'b1;
            res.result     = rem ? '0 : MDIV_INT_MIN;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdiv_special.sv
// Combinational detector for divide cases resolved without the divider.
// Zero latency; no handshake.
module mdiv_special
    import mdiv_pkg::*;
(
    input  logic                 unsign_i,
    input  logic                 rem_i,
    input  logic [MDIV_XLEN-1:0] dividend_i,
    input  logic [MDIV_XLEN-1:0] divisor_i,
    output logic                 is_special_o,
    output logic [MDIV_XLEN-1:0] special_result_o
);

    mdiv_special_t spec;

    assign spec             = mdiv_special_result(unsign_i, rem_i, dividend_i, divisor_i);
    assign is_special_o     = spec.is_special;
    assign special_result_o = spec.result;

endmodule

// File: rtl/mdiv_ctrl.sv
// Execute-stage controller driving the mdivider wrapper for DIV/DIVU/REM/REMU.
// Optional last-result cache: define MDIV_LAST_RESULT_CACHE_EN.
module mdiv_ctrl
    import mdiv_pkg::*;
#(
    parameter int XLEN         = MDIV_XLEN,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_unsign,
    input  logic            req_rem,
    input  logic [XLEN-1:0] req_dividend,
    input  logic [XLEN-1:0] req_divisor,
    input  logic            flush,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] res_data,
    output logic            div_enable,
    output logic            div_unsign,
    output logic            div_mod,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_done
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    mdiv_state_t     state_q, state_d;
    logic            unsign_q, unsign_d;
    logic            rem_q, rem_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            used_div_q, used_div_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;

    logic            is_special;
    logic [XLEN-1:0] special_result;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;
    logic            cache_store;
    logic            cache_clr;

    mdiv_special u_special (
        .unsign_i         (req_unsign),
        .rem_i            (req_rem),
        .dividend_i       (req_dividend),
        .divisor_i        (req_divisor),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    assign cache_store = (state_q == MDIV_BUSY) && !flush && div_done;
    assign cache_clr   = (state_q == MDIV_BUSY) && flush;

`ifdef MDIV_LAST_RESULT_CACHE_EN
    logic            c_vld_q;
    logic            c_unsign_q;
    logic            c_rem_q;
    logic [XLEN-1:0] c_dividend_q;
    logic [XLEN-1:0] c_divisor_q;
    logic [XLEN-1:0] c_result_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld_q      <= 1'b0;
            c_unsign_q   <= 1'b0;
            c_rem_q      <= 1'b0;
            c_dividend_q <= '0;
            c_divisor_q  <= '0;
            c_result_q   <= '0;
        end else if (cache_clr) begin
            c_vld_q      <= 1'b0;
        end else if (cache_store) begin
            c_vld_q      <= 1'b1;
            c_unsign_q   <= unsign_q;
            c_rem_q      <= rem_q;
            c_dividend_q <= dividend_q;
            c_divisor_q  <= divisor_q;
            c_result_q   <= div_result;
        end
    end

    assign cache_hit    = c_vld_q && (c_unsign_q == req_unsign) && (c_rem_q == req_rem)
                       && (c_dividend_q == req_dividend) && (c_divisor_q == req_divisor);
    assign cache_result = c_result_q;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_d     = state_q;
        unsign_d    = unsign_q;
        rem_d       = rem_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        res_data_d  = res_data_q;
        used_div_d  = used_div_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            MDIV_IDLE: begin
                if (req_valid && !flush) begin
                    unsign_d   = req_unsign;
                    rem_d      = req_rem;
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    if (is_special) begin
                        state_d    = MDIV_DONE;
                        res_data_d = special_result;
                        used_div_d = 1'b0;
                    end else if (cache_hit) begin
                        state_d    = MDIV_DONE;
                        res_data_d = cache_result;
                        used_div_d = 1'b0;
                    end else begin
                        state_d    = MDIV_BUSY;
                        used_div_d = 1'b1;
                    end
                end
            end
            // A kill outranks a coincident done; the divider still needs its drain.
            MDIV_BUSY: begin
                if (flush) begin
                    state_d     = MDIV_DRAIN;
                    drain_cnt_d = '0;
                end else if (div_done) begin
                    state_d    = MDIV_DONE;
                    res_data_d = div_result;
                end
            end
            MDIV_DONE: begin
                state_d     = used_div_q ? MDIV_DRAIN : MDIV_IDLE;
                drain_cnt_d = '0;
            end
            MDIV_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = MDIV_IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = MDIV_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MDIV_IDLE;
            unsign_q    <= 1'b0;
            rem_q       <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            res_data_q  <= '0;
            used_div_q  <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            unsign_q    <= unsign_d;
            rem_q       <= rem_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            res_data_q  <= res_data_d;
            used_div_q  <= used_div_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign res_valid    = (state_q == MDIV_DONE);
    assign res_data     = res_data_q;
    assign div_enable   = (state_q == MDIV_BUSY);
    assign div_unsign   = unsign_q;
    assign div_mod      = rem_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign stall        = req_valid && !res_valid && !flush;

endmodule

// File: tb/tb_mdiv_ctrl.sv
// Scoreboard bench for mdiv_ctrl with a fixed-latency behavioural divider.
// Cache expectations follow MDIV_LAST_RESULT_CACHE_EN.
module tb_mdiv_ctrl;

    localparam int DIV_LAT = 4;
    localparam int DRAIN   = 2;
`ifdef MDIV_LAST_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_unsign, req_rem, flush;
    logic [31:0] req_dividend, req_divisor;
    logic        stall, res_valid, div_enable, div_unsign, div_mod, div_done;
    logic [31:0] res_data, div_dividend, div_divisor, div_result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];
    bit          prev_div = 1'b0;
    int          mcnt     = 0;

    always #5 sys_clk = ~sys_clk;

    mdiv_ctrl #(.XLEN(32), .DRAIN_CYCLES(DRAIN)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_unsign   (req_unsign),
        .req_rem      (req_rem),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .flush        (flush),
        .stall        (stall),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .div_enable   (div_enable),
        .div_unsign   (div_unsign),
        .div_mod      (div_mod),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .div_done     (div_done)
    );

    function automatic logic [31:0] ref_div(input logic u, input logic r,
                                            input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)                                     return r ? a : 32'hFFFF_FFFF;
        if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        if (u)                                              return r ? a % b : a / b;
        return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    function automatic bit is_spec(input logic u, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Divider model: done in the DIV_LAT-th enabled cycle, restarts whenever enable drops.
    always @(posedge sys_clk) mcnt <= div_enable ? mcnt + 1 : 0;
    assign div_done   = div_enable && (mcnt == DIV_LAT - 1);
    assign div_result = ref_div(div_unsign, div_mod, div_dividend, div_divisor);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge sys_clk) begin
        if (rst_n && res_valid) begin
            if (sb_q.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
            else                  chk("res_data", res_data, sb_q.pop_front());
        end
    end

    // Call at posedge+1; returns at posedge+1 of the cycle after res_valid.
    task automatic run_op(input logic u, input logic r, input logic [31:0] a,
                          input logic [31:0] b, input bit divp);
        int k, lat, exp_k;
        bit got, seen_en, bad_ctl;
        exp_k = (prev_div ? DRAIN : 0) + (divp ? DIV_LAT + 1 : 1);
        sb_q.push_back(ref_div(u, r, a, b));
        req_unsign = u; req_rem = r; req_dividend = a; req_divisor = b; req_valid = 1'b1;
        got = 0; seen_en = 0; bad_ctl = 0; lat = -1; k = 0;
        while (!got && k < 200) begin
            @(negedge sys_clk);
            if (k == 0) chk("stall_on_req", stall, 1);
            if (div_enable) begin
                seen_en = 1;
                if (div_unsign !== u || div_mod !== r || div_dividend !== a || div_divisor !== b)
                    bad_ctl = 1;
            end
            if (res_valid) begin
                got = 1;
                lat = k;
                chk("stall_at_res", stall, 0);
            end
            k++;
        end
        chk("res_seen", got, 1);
        chk("latency", lat, exp_k);
        chk("div_used", seen_en, divp);
        if (seen_en) chk("busy_ctl_stable", bad_ctl, 0);
        prev_div = divp;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_enable(input string tag);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!div_enable && n < 50);
        chk(tag, div_enable, 1);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_div_enable"}, div_enable, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_data"}, res_data, 0);
        chk({pfx, "_div_unsign"}, div_unsign, 0);
        chk({pfx, "_div_mod"}, div_mod, 0);
        chk({pfx, "_div_dividend"}, div_dividend, 0);
        chk({pfx, "_div_divisor"}, div_divisor, 0);
        chk({pfx, "_stall"}, stall, 0);
    endtask

    // Flush in the 3rd BUSY cycle, then DIVU 9/3 must wait out the drain.
    task automatic flush_test();
        req_unsign = 1; req_rem = 0; req_dividend = 32'd50; req_divisor = 32'd5; req_valid = 1;
        wait_enable("flush_busy_start");
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        flush = 1'b1;
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk("flush_still_busy", div_enable, 1);
        chk("flush_stall", stall, 0);
        @(posedge sys_clk); #1;
        flush = 1'b0;
        chk("drain_enable_low", div_enable, 0);
        prev_div = 1'b1;
        run_op(1, 0, 32'd9, 32'd3, 1);
    endtask

    initial begin
        logic        u, r;
        logic [31:0] a, b;
        rst_n = 0; req_valid = 0; req_unsign = 0; req_rem = 0; flush = 0;
        req_dividend = 0; req_divisor = 0;
        repeat (2) @(negedge sys_clk);
        chk_outputs_zero("reset");
        rst_n = 1;
        @(posedge sys_clk); #1;

        run_op(1, 0, 32'd100, 32'd7, 1);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(0, 0, 32'd5, 32'd0, 0);
        run_op(1, 1, 32'd5, 32'd0, 0);
        run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);

        for (int i = 0; i < 6; i++) begin
            u = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            run_op(u, r, a, b, !is_spec(u, a, b));
        end

        flush_test();

        req_unsign = 1; req_rem = 0; req_dividend = 32'd1000; req_divisor = 32'd10; req_valid = 1;
        wait_enable("rst_busy_start");
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        @(negedge sys_clk);
        rst_n = 1'b1;
        prev_div = 1'b0;
        @(posedge sys_clk); #1;

        run_op(1, 0, 32'd100, 32'd7, 1);
        run_op(1, 0, 32'd100, 32'd7, !CACHE);
        flush_test();
        run_op(1, 0, 32'd100, 32'd7, 1);

        repeat (8) @(negedge sys_clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdiv_ctrl.md
# mdiv_ctrl

Execute-stage controller that sits directly upstream of the `mdivider` wrapper and drives it for RISC-V DIV/DIVU/REM/REMU. It captures the operands and resolves the RISC-V special cases (divide-by-zero, signed overflow) locally, without the divider. Otherwise it runs the enable/done handshake with `mdivider`, holds the pipeline stall for the whole operation, and returns one registered result.

## Interface
Parameters:
- XLEN, 32, operand/result width; must equal the `mdivider` width.
- DRAIN_CYCLES, 2, minimum number of cycles `div_enable` stays low after a divider operation, so the IP reset (`aresetn = enable && !done`) is held long enough.

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  EX stage holds a divide op. Held high with stable operands until the cycle `res_valid` is seen.
- req_unsign  in  1  1 = DIVU/REMU.
- req_rem  in  1  1 = REM/REMU (remainder), 0 = quotient.
- req_dividend  in  XLEN  rs1.
- req_divisor  in  XLEN  rs2.
- flush  in  1  pipeline kill; aborts any in-flight op.
- stall  out  1  combinational: `req_valid && !res_valid && !flush`.
- res_valid  out  1  one-cycle pulse; the result is valid this cycle.
- res_data  out  XLEN  result, valid only while `res_valid` is high.
- div_enable  out  1  to `mdivider.enable`.
- div_unsign  out  1  to `mdivider.unsign`.
- div_mod  out  1  to `mdivider.mod`; 1 selects the remainder.
- div_dividend  out  XLEN  to `mdivider.dividend`.
- div_divisor  out  XLEN  to `mdivider.divisor`.
- div_result  in  XLEN  from `mdivider.result`.
- div_done  in  1  from `mdivider.done`.

## Operation
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - On `req_valid && !flush`, latch op, dividend and divisor into registers; the `div_*` operand outputs come from these registers.
  - Special case detected: go to DONE with the computed result; no divider use.
  - Otherwise: go to BUSY.
- Special cases:
  - Divisor == 0: quotient = all ones (0xFFFFFFFF); remainder = dividend.
  - Signed, dividend == 0x80000000, divisor == 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- BUSY:
  - `div_enable` = 1.
  - On `div_done`, register `div_result` into `res_data` and go to DONE.
  - On `flush`, go to DRAIN with no result.
- DONE:
  - `res_valid` = 1 and `div_enable` = 0.
  - Go to DRAIN if the divider was used, else to IDLE.
  - A new request is never accepted in DONE.
- DRAIN:
  - `div_enable` = 0 for DRAIN_CYCLES cycles, then go to IDLE.
  - `req_valid` during DRAIN keeps `stall` high and is not accepted.
- Flush in DONE: `res_valid` is still produced; the pipeline ignores it.
- Flush in IDLE: no request is accepted.
- Reset, at any time including mid-operation: IDLE.
- Reset values: all outputs 0; `res_data` = 0; drain counter = 0.

## Timing
- Request accepted at the edge ending cycle N.
- Special case or cache hit: `res_valid` in cycle N+1.
- Divider path:
  - BUSY (`div_enable` = 1) from N+1.
  - `div_done` seen in cycle D.
  - `res_valid` in D+1.
  - `div_enable` = 0 from D+1 through D+DRAIN_CYCLES+1 (DONE plus DRAIN).
- Back-to-back divider ops: the earliest next accept is cycle D+DRAIN_CYCLES+2.
- `div_unsign`, `div_mod` and the operands are stable for the whole BUSY phase.

## Configuration
- Macro `MDIV_LAST_RESULT_CACHE_EN`.
- Defined:
  - Store {valid, unsign, rem, dividend, divisor, result} of the last divider-path result.
  - A request matching every field is a hit: go to DONE with the stored result in N+1, no DRAIN.
  - Reset and `flush` during BUSY clear `valid`.
- Undefined: no storage; every non-special request takes the divider path.

## Structure
- Shared package `mdiv_pkg`:
  - State enum `mdiv_state_t`.
  - Constants `MDIV_ALL_ONES` and `MDIV_INT_MIN`.
  - The special-case result function.
- One sub-module: `mdiv_special`, combinational. Takes {unsign, rem, dividend, divisor}; outputs {is_special, special_result}.
- Cache registers are inline, guarded by the macro.

## Test plan
- DIVU 100 / 7:
  - `stall` high from N until `res_valid`.
  - `res_data` = 14 in D+1.
  - `div_enable` low for 2 cycles after `div_done`.
- REM signed −7 / 2: `res_data` = 0xFFFFFFFF (−1), with `div_mod` = 1 and `div_unsign` = 0 throughout BUSY.
- DIV 5 / 0 gives 0xFFFFFFFF at N+1; REMU 5 / 0 gives 5. `div_enable` never rises for either.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0. Both at N+1.
- `flush` in the 3rd BUSY cycle:
  - No `res_valid`.
  - DRAIN for 2 cycles, then a new DIVU 9 / 3 returns 3.
  - Async `rst_n` low mid-BUSY forces all outputs to 0 immediately.
- With `MDIV_LAST_RESULT_CACHE_EN` defined: DIVU 100 / 7 twice. The second result is 14 at N+1 with no `div_enable` pulse. After an intervening flush, the repeat takes the divider path.
